// File: rtl/wave_capture_writer.sv
// Decimating waveform writer into a flop-based circular column buffer.
// Ports: CLOCK, RESET (async, active-high), sample_tick, mic_in[11:0],
//   freeze, rd_col[6:0] -> wave_sample[9:0], wr_ptr[6:0], frozen,
//   frame_done. Optional macro WAVE_PEAK_HOLD_EN selects a window
//   peak column value instead of the last sample of the window.
module wave_capture_writer #(
  parameter int COLUMNS = 96,
  parameter int DECIM   = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        sample_tick,
  input  logic [11:0] mic_in,
  input  logic        freeze,
  input  logic [6:0]  rd_col,
  output logic [9:0]  wave_sample,
  output logic [6:0]  wr_ptr,
  output logic        frozen,
  output logic        frame_done
);

  localparam int WW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WW-1:0] WLAST = WW'(DECIM - 1);
  localparam logic [WW-1:0] WONE  = WW'(1);
  localparam logic [6:0]    PLAST = 7'(COLUMNS - 1);
  localparam logic [7:0]    NCOL  = 8'(COLUMNS);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FROZEN
  } state_t;

  state_t      state_q;
  logic [WW-1:0] win_q;
  logic [6:0]  ptr_q;
  logic [9:0]  ws_q;
  logic        frozen_q;
  logic        fdone_q;
  logic [9:0]  mem_q [COLUMNS];

  logic [9:0]  samp;
  logic [9:0]  col_val;
  logic        acc;
  logic        close;
  logic [7:0]  rd_sum;
  logic [7:0]  rd_addr;
  logic        rd_ok;
  logic        unused_lsb;

  assign samp       = mic_in[11:2];
  assign unused_lsb = ^mic_in[1:0];

`ifdef WAVE_PEAK_HOLD_EN
  logic [9:0] peak_q;
  assign col_val = (samp > peak_q) ? samp : peak_q;
`else
  assign col_val = samp;
`endif

  // Ticks are dropped entirely while frozen.
  assign acc   = sample_tick && (state_q != FROZEN);
  assign close = acc && (win_q == WLAST);

  // rd_col counts from the oldest slot, which is the next one written.
  assign rd_sum  = {1'b0, ptr_q} + {1'b0, rd_col};
  assign rd_addr = (rd_sum >= NCOL) ? rd_sum - NCOL : rd_sum;
  assign rd_ok   = ({1'b0, rd_col} < NCOL);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= RUN;
      win_q    <= '0;
      ptr_q    <= '0;
      ws_q     <= '0;
      frozen_q <= 1'b0;
      fdone_q  <= 1'b0;
`ifdef WAVE_PEAK_HOLD_EN
      peak_q   <= '0;
`endif
      for (int i = 0; i < COLUMNS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fdone_q <= 1'b0;
      ws_q    <= rd_ok ? mem_q[rd_addr[6:0]] : '0;

      if (close) begin
        mem_q[ptr_q] <= col_val;
        ptr_q        <= (ptr_q == PLAST) ? '0 : ptr_q + 7'd1;
        fdone_q      <= (ptr_q == PLAST);
        win_q        <= '0;
`ifdef WAVE_PEAK_HOLD_EN
        peak_q       <= '0;
`endif
      end else if (acc) begin
        win_q  <= win_q + WONE;
`ifdef WAVE_PEAK_HOLD_EN
        peak_q <= col_val;
`endif
      end

      unique case (state_q)
        RUN: begin
          if (freeze) begin
            // Nothing accumulated and no tick now: stop at once.
            if (close || (win_q == '0 && !sample_tick)) begin
              state_q  <= FROZEN;
              frozen_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!freeze) begin
            state_q <= RUN;
          end else if (close) begin
            state_q  <= FROZEN;
            frozen_q <= 1'b1;
          end
        end
        FROZEN: begin
          if (!freeze) begin
            state_q  <= RUN;
            frozen_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  assign wave_sample = ws_q;
  assign wr_ptr      = ptr_q;
  assign frozen      = frozen_q;
  assign frame_done  = fdone_q;

endmodule

// File: tb/tb_wave_capture_writer.sv
// Directed bench for wave_capture_writer with a queue-based window model.
// Checks all outputs every cycle plus hand-computed literal points.
module tb_wave_capture_writer;

  localparam int C = 96;
  localparam int D = 4;

`ifdef WAVE_PEAK_HOLD_EN
  localparam int T1_EXP = 'h3FF;
`else
  localparam int T1_EXP = 'h080;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        sample_tick = 1'b0;
  logic [11:0] mic_in = '0;
  logic        freeze = 1'b0;
  logic [6:0]  rd_col = '0;
  logic [9:0]  wave_sample;
  logic [6:0]  wr_ptr;
  logic        frozen;
  logic        frame_done;

  wave_capture_writer #(.COLUMNS(C), .DECIM(D)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .sample_tick(sample_tick),
    .mic_in(mic_in),
    .freeze(freeze),
    .rd_col(rd_col),
    .wave_sample(wave_sample),
    .wr_ptr(wr_ptr),
    .frozen(frozen),
    .frame_done(frame_done)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mem [C];
  int win [$];
  int m_ptr;
  int m_ws;
  bit m_frozen;
  bit m_fd;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) m_mem[i] = 0;
    win.delete();
    m_ptr = 0;
    m_ws = 0;
    m_frozen = 0;
    m_fd = 0;
  endtask

  function automatic int col_value();
    int v;
`ifdef WAVE_PEAK_HOLD_EN
    v = 0;
    foreach (win[i]) if (win[i] > v) v = win[i];
`else
    v = win[win.size() - 1];
`endif
    return v;
  endfunction

  task automatic model_edge(bit tk, int mic, bit frz, int rdc);
    m_ws = (rdc >= C) ? 0 : m_mem[(m_ptr + rdc) % C];
    m_fd = 0;
    if (m_frozen) begin
      if (!frz) m_frozen = 0;
    end else begin
      if (tk) win.push_back(mic >> 2);
      if (win.size() == D) begin
        m_mem[m_ptr] = col_value();
        m_fd = (m_ptr == C - 1);
        m_ptr = (m_ptr + 1) % C;
        win.delete();
      end
      if (frz && win.size() == 0) m_frozen = 1;
    end
  endtask

  task automatic compare();
    chk("wave_sample", int'(wave_sample), m_ws);
    chk("wr_ptr", int'(wr_ptr), m_ptr);
    chk("frozen", int'(frozen), int'(m_frozen));
    chk("frame_done", int'(frame_done), int'(m_fd));
  endtask

  task automatic step(bit tk, logic [11:0] mic, bit frz, int rdc);
    sample_tick = tk;
    mic_in = mic;
    freeze = frz;
    rd_col = 7'(rdc);
    @(posedge CLOCK);
    model_edge(tk, int'(mic), frz, rdc);
    #1;
    compare();
  endtask

  task automatic do_reset();
    sample_tick = 0;
    freeze = 0;
    rd_col = '0;
    RESET = 1;
    model_reset();
    #2;
    chk("rst_ws", int'(wave_sample), 0);
    chk("rst_ptr", int'(wr_ptr), 0);
    chk("rst_frozen", int'(frozen), 0);
    chk("rst_fdone", int'(frame_done), 0);
    @(posedge CLOCK);
    #1;
    RESET = 0;
  endtask

  initial begin
    int fd_cnt;
    logic [11:0] t1 [4];
    t1[0] = 12'h100;
    t1[1] = 12'hFFC;
    t1[2] = 12'h040;
    t1[3] = 12'h200;

    do_reset();

    for (int i = 0; i < 4; i++) step(1, t1[i], 0, 0);
    chk("t1_ptr", int'(wr_ptr), 1);
    step(0, '0, 0, 95);
    chk("t1_col", int'(wave_sample), T1_EXP);

    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < C * D; i++) begin
      step(1, 12'h800, 0, 0);
      if (frame_done) fd_cnt++;
    end
    chk("frame_cnt", fd_cnt, 1);
    chk("wrap_ptr", int'(wr_ptr), 0);
    for (int i = 0; i < C; i++) begin
      step(0, '0, 0, i);
      chk("full_rd", int'(wave_sample), 'h200);
    end
    step(0, '0, 0, 100);
    chk("rd_oob", int'(wave_sample), 0);

    step(0, '0, 1, 0);
    chk("frz_idle", int'(frozen), 1);
    step(0, '0, 0, 0);
    chk("unfrz_idle", int'(frozen), 0);

    step(1, 12'h100, 0, 0);
    step(1, 12'h300, 0, 0);
    step(0, '0, 1, 0);
    chk("drain_nofrz", int'(frozen), 0);
    step(1, 12'h500, 1, 0);
    step(1, 12'h700, 1, 0);
    chk("drain_ptr", int'(wr_ptr), 1);
    chk("drain_frz", int'(frozen), 1);
    for (int i = 0; i < 8; i++) step(1, 12'hFFF, 1, 0);
    chk("hold_ptr", int'(wr_ptr), 1);
    step(0, '0, 0, 0);
    chk("resume", int'(frozen), 0);
    for (int i = 0; i < 4; i++) step(1, 12'h004, 0, 0);
    chk("fresh_ptr", int'(wr_ptr), 2);
    step(0, '0, 0, 94);
    chk("drain_col", int'(wave_sample), 'h1C0);
    step(0, '0, 0, 95);
    chk("fresh_col", int'(wave_sample), 'h001);

    for (int i = 0; i < 3; i++) step(1, 12'h123, 0, 0);
    do_reset();
    chk("rst_mid_ptr", int'(wr_ptr), 0);
    for (int i = 0; i < C; i++) begin
      step(0, '0, 0, i);
      chk("rst_rd", int'(wave_sample), 0);
    end

    for (int i = 0; i < 3; i++) step(1, 12'h404, 0, 0);
    step(1, 12'h408, 0, 0);
    chk("rdw_old", int'(wave_sample), 0);
    chk("rdw_ptr", int'(wr_ptr), 1);
    step(0, '0, 0, 95);
    chk("rdw_new", int'(wave_sample), 'h102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
